// File: rtl/jtag_mem_arb_pkg.sv
// Shared types and default widths for the JTAG/core memory arbiter.
package jtag_mem_arb_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 64;

    typedef enum logic {
        OWN_JTAG = 1'b0,
        OWN_CORE = 1'b1
    } owner_e;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_st_e;

endpackage

// File: rtl/jtag_mem_arb_fair.sv
// Combinational grant decision (JTAG priority) plus the starvation counter
// that forces a core grant after STARVE_MAX consecutive JTAG wins.
module jtag_mem_arb_fair
    import jtag_mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic CLK,
    input  logic RESET,
    input  logic j_req_i,
    input  logic c_req_i,
    input  logic locked_i,
    input  logic lock_exit_i,
    output logic grant_j,
    output logic grant_c,
    output logic winner
);

    localparam logic [7:0] SMAX = 8'(STARVE_MAX);

    logic [7:0] starve_q;
    logic [7:0] starve_d;
    logic       c_eff;
    logic       at_max;

    always_comb begin
        // Grants are suppressed during reset so no access is promised that reset would drop.
        c_eff    = c_req_i && !locked_i && !RESET;
        at_max   = (starve_q == SMAX);
        grant_j  = j_req_i && !RESET && !(c_eff && at_max);
        grant_c  = c_eff && (!j_req_i || at_max);
        winner   = grant_c ? OWN_CORE : OWN_JTAG;

        starve_d = starve_q;
        if (lock_exit_i || grant_c || !c_req_i) begin
            starve_d = '0;
        end else if (grant_j && c_eff && !at_max) begin
            starve_d = starve_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/jtag_mem_arbiter.sv
// Single-port memory arbiter between the JTAG loader and the core port.
// Define JTAG_ARB_LOCK_EN to add the J_LOCK port and exclusive-access lock FSM.
module jtag_mem_arbiter
    import jtag_mem_arb_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int STARVE_MAX = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          J_REQ,
    input  logic          J_WE,
    input  logic [AW-1:0] J_ADDR,
    input  logic [DW-1:0] J_WDATA,
    output logic          J_GNT,
    output logic          J_RVALID,
    output logic [DW-1:0] J_RDATA,
    input  logic          C_REQ,
    input  logic          C_WE,
    input  logic [AW-1:0] C_ADDR,
    input  logic [DW-1:0] C_WDATA,
    output logic          C_GNT,
    output logic          C_RVALID,
    output logic [DW-1:0] C_RDATA,
`ifdef JTAG_ARB_LOCK_EN
    input  logic          J_LOCK,
`endif
    output logic          LOCKED,
    output logic          M_EN,
    output logic          M_WE,
    output logic [AW-1:0] M_ADDR,
    output logic [DW-1:0] M_WDATA,
    input  logic [DW-1:0] M_RDATA
);

    logic          grant_j;
    logic          grant_c;
    logic          winner;
    logic          locked;
    logic          lock_exit;
    logic          m_en_q;
    logic          m_we_q;
    logic [AW-1:0] m_addr_q;
    logic [DW-1:0] m_wdata_q;
    owner_e        m_own_q;
    logic          tag_vld_q;
    owner_e        tag_own_q;

`ifdef JTAG_ARB_LOCK_EN
    lock_st_e lock_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            lock_q <= ST_UNLOCKED;
        end else begin
            unique case (lock_q)
                ST_UNLOCKED: if (J_LOCK)  lock_q <= ST_LOCKED;
                ST_LOCKED:   if (!J_LOCK) lock_q <= ST_UNLOCKED;
            endcase
        end
    end

    assign locked    = (lock_q == ST_LOCKED);
    assign lock_exit = locked && !J_LOCK;
`else
    assign locked    = 1'b0;
    assign lock_exit = 1'b0;
`endif

    jtag_mem_arb_fair #(
        .STARVE_MAX (STARVE_MAX)
    ) u_fair (
        .CLK         (CLK),
        .RESET       (RESET),
        .j_req_i     (J_REQ),
        .c_req_i     (C_REQ),
        .locked_i    (locked),
        .lock_exit_i (lock_exit),
        .grant_j     (grant_j),
        .grant_c     (grant_c),
        .winner      (winner)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_own_q   <= OWN_JTAG;
            tag_vld_q <= 1'b0;
            tag_own_q <= OWN_JTAG;
        end else begin
            m_en_q <= grant_j || grant_c;
            m_we_q <= grant_c ? C_WE : (grant_j && J_WE);
            if (grant_j || grant_c) begin
                m_addr_q  <= grant_c ? C_ADDR  : J_ADDR;
                m_wdata_q <= grant_c ? C_WDATA : J_WDATA;
                m_own_q   <= owner_e'(winner);
            end
            // The tag follows the read actually on the memory port, so a write issued
            // right behind it cannot steal its response.
            tag_vld_q <= m_en_q && !m_we_q;
            if (m_en_q && !m_we_q) begin
                tag_own_q <= m_own_q;
            end
        end
    end

    assign J_GNT    = grant_j;
    assign C_GNT    = grant_c;
    assign LOCKED   = locked;
    assign M_EN     = m_en_q;
    assign M_WE     = m_we_q;
    assign M_ADDR   = m_addr_q;
    assign M_WDATA  = m_wdata_q;
    assign J_RVALID = tag_vld_q && (tag_own_q == OWN_JTAG);
    assign C_RVALID = tag_vld_q && (tag_own_q == OWN_CORE);
    assign J_RDATA  = J_RVALID ? M_RDATA : '0;
    assign C_RDATA  = C_RVALID ? M_RDATA : '0;

endmodule

// File: doc/jtag_mem_arbiter.md
# jtag_mem_arbiter

Shares one single-port synchronous 64-bit memory between the JTAG memory-access shift register (debug loader, already synchronized into CLK) and a core-side requester. Each cycle it grants at most one request, drives the memory port from registers, and routes read data back to whichever port issued the read. JTAG normally has priority, and a starvation counter bounds how long the core port can be held off.

## Interface
- AW, 32, address width
- DW, 64, data width
- STARVE_MAX, 8, max consecutive JTAG grants while core waits (legal range 1..255)
- CLK  in  1  clock
- RESET  in  1  reset, synchronous, active-high
- J_REQ / J_WE  in  1  JTAG request / write-not-read
- J_ADDR  in  AW  JTAG address
- J_WDATA  in  DW  JTAG write data
- J_GNT  out  1  JTAG request accepted this cycle
- J_RVALID  out  1  JTAG read data valid
- J_RDATA  out  DW  JTAG read data
- C_REQ, C_WE, C_ADDR, C_WDATA, C_GNT, C_RVALID, C_RDATA: core port, same widths and meaning as the J_* signals
- J_LOCK  in  1  JTAG exclusive-access request (present only with JTAG_ARB_LOCK_EN)
- LOCKED  out  1  core port currently blocked by lock
- M_EN / M_WE  out  1  memory enable / write
- M_ADDR  out  AW;  M_WDATA  out  DW  memory address / write data
- M_RDATA  in  DW  memory read data, valid the cycle after M_EN && !M_WE

## Operation
- Requesters hold REQ/WE/ADDR/WDATA stable until GNT. GNT is combinational from REQ, lock state and starvation count.
- Grant rule:
  - Only one REQ high: grant it.
  - Both high: grant JTAG, unless STARVE == STARVE_MAX, then grant core.
  - LOCKED: C_GNT = 0 always.
- STARVE (width 8):
  - +1 on a JTAG grant while C_REQ is high and not LOCKED.
  - Clears on any core grant, and while C_REQ is low.
  - Saturates at STARVE_MAX.
- Memory port is registered. On a grant, the next cycle drives M_EN=1, M_WE, M_ADDR and M_WDATA from the winner. Otherwise M_EN=0 and M_WE=0, with address and data holding their last values.
- Read owner tag: a 1-bit register plus a valid bit, captured with M_EN && !M_WE. The cycle after, the tagged port's RVALID=1 and its RDATA = M_RDATA (combinational passthrough). The untagged port's RVALID=0 and its RDATA=0.
- Writes produce no response.
- Lock FSM states: UNLOCKED and LOCKED.
  - UNLOCKED -> LOCKED when J_LOCK=1. Any core access already granted completes normally.
  - LOCKED -> UNLOCKED when J_LOCK=0. STARVE is cleared on exit.
  - LOCKED output = state == LOCKED (registered).
- Reset values:
  - Outputs: all GNT, RVALID, M_EN, M_WE and LOCKED = 0; M_ADDR, M_WDATA and both RDATA = 0.
  - Internal: STARVE = 0; tag valid = 0; state UNLOCKED.

## Timing
- Grant in cycle t -> M_EN in t+1 -> RVALID/RDATA in t+2.
- Throughput is one access per cycle, back-to-back, with either owner.
- Read in t+1 and write in t+2 can overlap. The response always follows the tag captured at t+1.
- Reset mid-operation: a read issued in the cycle before RESET produces no RVALID. No pending state survives reset.
- J_LOCK rising in cycle t: C_GNT = 0 from cycle t+1. A core grant in cycle t itself is still honoured.
- Simultaneous STARVE == STARVE_MAX and J_LOCK rising in the same cycle: the core grant wins for that cycle, then the lock applies.

## Configuration
- JTAG_ARB_LOCK_EN defined: J_LOCK port and the lock FSM exist, behaving as above.
- JTAG_ARB_LOCK_EN undefined:
  - No J_LOCK port and no lock FSM.
  - LOCKED is tied to 0.
  - Arbitration uses only the priority and starvation rules.

## Structure
- Package jtag_mem_arb_pkg holds:
  - owner enum (OWN_JTAG, OWN_CORE);
  - lock state enum (ST_UNLOCKED, ST_LOCKED);
  - default AW/DW constants.
- One sub-module, jtag_mem_arb_fair, holds the combinational grant decision and the STARVE counter. Its outputs are grant_j, grant_c and winner.
- The top level holds the memory-port registers, the read-tag pipeline and the lock FSM.

## Test plan
- JTAG-only traffic:
  - JTAG write 0xDEADBEEF_00000001 to 0x100, then read 0x100.
  - Required: M_EN/M_WE=1 one cycle after the write grant; J_RVALID two cycles after the read grant with J_RDATA = 0xDEADBEEF_00000001; C_RVALID stays 0.
- Contention (STARVE_MAX=8):
  - J_REQ and C_REQ both held high.
  - Required: 8 JTAG grants, then 1 core grant, repeating; STARVE returns to 0 after each core grant.
- Interleaved reads:
  - JTAG reads 0x0 and core reads 0x8 on consecutive cycles.
  - Required: J_RVALID then C_RVALID on consecutive cycles, each with the correct data.
- Reset mid-read:
  - RESET asserted the cycle after a read grant.
  - Required: no RVALID on either port; all outputs 0 the cycle after RESET.
- Lock (macro defined):
  - J_LOCK=1 while C_REQ is held.
  - Required: LOCKED=1 and C_GNT=0 for the whole lock; a core grant occurs within 1 cycle of J_LOCK=0.
- Macro undefined:
  - Same stimulus as the lock test, minus J_LOCK.
  - Required: LOCKED remains 0 and the starvation pattern matches the contention test.
